// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle add/sub/logic/compare ops and serial (1 bit per
// cycle) shifts, wrapped in a valid/ready handshake so the core can stall.
module iterative_alu #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Low two bits of the shift op codes: 00 sll, 01 sra, 10 srl.
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;   // also the shift accumulator
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         sh_op_q, sh_op_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_illegal;
  logic               is_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   shifted;

  assign shamt    = src_b[SHAMT_W-1:0];
  assign is_shift = (ALU_control == 4'b1000) || (ALU_control == 4'b1001) ||
                    (ALU_control == 4'b1010);

  // Single-cycle datapath for the non-shift ops; unknown codes yield 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (ALU_control)
      4'b0000: alu_res = src_a + src_b;
      4'b0001: alu_res = src_a - src_b;
      4'b0010: alu_res = src_a & src_b;
      4'b0011: alu_res = src_a | src_b;
      4'b0100: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      4'b0110: alu_res = src_a ^ src_b;
      4'b1000, 4'b1001, 4'b1010: alu_res = '0;  // handled by the shifter
      default: alu_illegal = 1'b1;
    endcase
  end

  // One-bit step of the serial shifter, applied to the accumulator.
  always_comb begin
    case (sh_op_q)
      SH_SLL:  shifted = {result_q[WIDTH-2:0], 1'b0};
      SH_SRA:  shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: shifted = {1'b0, result_q[WIDTH-1:1]};
    endcase
  end

  // Next-state and datapath-register logic for the IDLE/SHIFT/DONE FSM.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    sh_op_d   = sh_op_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt == '0)) begin
            result_d  = src_a;
            zero_d    = (src_a == '0);
            illegal_d = 1'b0;
            state_d   = S_DONE;
          end else if (is_shift) begin
            result_d  = src_a;
            illegal_d = 1'b0;
            cnt_d     = shamt;
            sh_op_d   = ALU_control[1:0];
            state_d   = S_SHIFT;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_illegal;
            state_d   = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        result_d = shifted;
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          zero_d  = (shifted == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      sh_op_q   <= SH_SLL;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      sh_op_q   <= sh_op_d;
    end
  end

  assign in_ready  = reset_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
